lsu_mem_stage: RTL and testbench

Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs (address, store data, size selects, write enable) and performs data-memory and memory-mapped I/O accesses. Loaded data is returned size-aligned and sign/zero-extended, registered into the MEM/WB boundary. It owns the word-organised data RAM, the output peripheral registers, and the input synchronisers.

---
 rtl/lsu_mem_stage_if.sv | 35 +++
 rtl/lsu_mem_stage.sv | 174 +++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if
//   Pipeline-side bus between the EX/MEM register and the memory-stage LSU.
//   master: pipeline (drives the access, receives the registered load result)
//   slave : lsu_mem_stage
//   Signals:
//     insn_vld   MEM-stage instruction valid
//     mem_wren   1 = store
//     is_load    1 = load
//     addr       byte address (ALU result)
//     st_data    store data (rs2)
//     load_sel   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others load 0
//     store_sel  00 SB, 01 SH, 10 SW, 11 no store
//     ld_data    registered load result for WB
//     misalign   registered 1-cycle pulse for a misaligned access
interface lsu_mem_stage_if;
    logic        insn_vld;
    logic        mem_wren;
    logic        is_load;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [2:0]  load_sel;
    logic [1:0]  store_sel;
    logic [31:0] ld_data;
    logic        misalign;

    modport master (
        output insn_vld, mem_wren, is_load, addr, st_data, load_sel, store_sel,
        input  ld_data, misalign
    );

    modport slave (
        input  insn_vld, mem_wren, is_load, addr, st_data, load_sel, store_sel,
        output ld_data, misalign
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
//   Memory-stage load/store unit: word-organised data RAM, memory-mapped
//   output registers (LEDR, LEDG, HEX_LO, HEX_HI, LCD) and 2-flop input
//   synchronisers (SW, BTN). Loads are aligned, extended and registered
//   into the MEM/WB boundary with one cycle of latency.
//   Ports:
//     i_clk, i_rst_n   clock, synchronous active-low reset
//     bus              pipeline access bus (lsu_mem_stage_if.slave)
//     i_io_sw/i_io_btn asynchronous switch/button inputs
//     o_io_*           output peripheral registers
module lsu_mem_stage #(
    parameter int unsigned DMEM_DEPTH = 2048,
    parameter logic [31:0] DMEM_BASE  = 32'h0000_2000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    lsu_mem_stage_if.slave    bus,
    input  logic [31:0]       i_io_sw,
    input  logic [3:0]        i_io_btn,
    output logic [31:0]       o_io_ledr,
    output logic [31:0]       o_io_ledg,
    output logic [31:0]       o_io_hex_lo,
    output logic [31:0]       o_io_hex_hi,
    output logic [31:0]       o_io_lcd
);
    localparam int unsigned IDX_W      = $clog2(DMEM_DEPTH);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_DEPTH) << 2;

    localparam logic [29:0] A_LEDR   = 30'(32'h7000 >> 2);
    localparam logic [29:0] A_LEDG   = 30'(32'h7010 >> 2);
    localparam logic [29:0] A_HEX_LO = 30'(32'h7020 >> 2);
    localparam logic [29:0] A_HEX_HI = 30'(32'h7024 >> 2);
    localparam logic [29:0] A_LCD    = 30'(32'h7030 >> 2);
    localparam logic [29:0] A_SW     = 30'(32'h7800 >> 2);
    localparam logic [29:0] A_BTN    = 30'(32'h7810 >> 2);

    logic [31:0] dmem [DMEM_DEPTH];

    logic [31:0] sw_s1, sw_s2;
    logic [3:0]  btn_s1, btn_s2;

    logic [31:0]      dmem_off;
    logic [IDX_W-1:0] dmem_idx;
    logic [29:0]      word;
    logic             hit_dmem, hit_ledr, hit_ledg, hit_hex_lo, hit_hex_hi, hit_lcd;
    logic             hit_sw, hit_btn;
    logic             ld_mis, st_mis, access_mis;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic             store_en;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      ld_nxt;

    // Unsigned offset compare covers both range bounds: addresses below the
    // base wrap to large offsets.
    assign dmem_off   = bus.addr - DMEM_BASE;
    assign dmem_idx   = dmem_off[IDX_W+1:2];
    assign word       = bus.addr[31:2];
    assign hit_dmem   = dmem_off < DMEM_BYTES;
    assign hit_ledr   = word == A_LEDR;
    assign hit_ledg   = word == A_LEDG;
    assign hit_hex_lo = word == A_HEX_LO;
    assign hit_hex_hi = word == A_HEX_HI;
    assign hit_lcd    = word == A_LCD;
    assign hit_sw     = word == A_SW;
    assign hit_btn    = word == A_BTN;

    // LH (001) and LHU (101) share load_sel[1:0] = 01.
    assign ld_mis = ((bus.load_sel[1:0] == 2'b01) && bus.addr[0]) ||
                    ((bus.load_sel == 3'b010) && (bus.addr[1:0] != 2'b00));
    assign st_mis = ((bus.store_sel == 2'b01) && bus.addr[0]) ||
                    ((bus.store_sel == 2'b10) && (bus.addr[1:0] != 2'b00));
    assign access_mis = bus.insn_vld && (bus.mem_wren ? st_mis : (bus.is_load && ld_mis));

    always_comb begin
        be    = '0;
        wdata = bus.st_data;
        case (bus.store_sel)
            2'b00: begin
                be    = 4'b0001 << bus.addr[1:0];
                wdata = {4{bus.st_data[7:0]}};
            end
            2'b01: begin
                be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.st_data[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = '0;
        endcase
    end

    assign store_en = i_rst_n && bus.insn_vld && bus.mem_wren && !st_mis;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int unsigned b = 0; b < 4; b++)
            if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (store_en && hit_dmem)
            for (int unsigned b = 0; b < 4; b++)
                if (be[b]) dmem[dmem_idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_io_ledr   <= '0;
            o_io_ledg   <= '0;
            o_io_hex_lo <= '0;
            o_io_hex_hi <= '0;
            o_io_lcd    <= '0;
            sw_s1       <= '0;
            sw_s2       <= '0;
            btn_s1      <= '0;
            btn_s2      <= '0;
            bus.ld_data <= '0;
            bus.misalign <= 1'b0;
        end else begin
            if (store_en && hit_ledr)   o_io_ledr   <= merge(o_io_ledr,   wdata, be);
            if (store_en && hit_ledg)   o_io_ledg   <= merge(o_io_ledg,   wdata, be);
            if (store_en && hit_hex_lo) o_io_hex_lo <= merge(o_io_hex_lo, wdata, be);
            if (store_en && hit_hex_hi) o_io_hex_hi <= merge(o_io_hex_hi, wdata, be);
            if (store_en && hit_lcd)    o_io_lcd    <= merge(o_io_lcd,    wdata, be);
            sw_s1       <= i_io_sw;
            sw_s2       <= sw_s1;
            btn_s1      <= i_io_btn;
            btn_s2      <= btn_s1;
            bus.ld_data <= ld_nxt;
            bus.misalign <= access_mis;
        end
    end

    always_comb begin
        rd_word = '0;
        if (hit_dmem)        rd_word = dmem[dmem_idx];
        else if (hit_ledr)   rd_word = o_io_ledr;
        else if (hit_ledg)   rd_word = o_io_ledg;
        else if (hit_hex_lo) rd_word = o_io_hex_lo;
        else if (hit_hex_hi) rd_word = o_io_hex_hi;
        else if (hit_lcd)    rd_word = o_io_lcd;
        else if (hit_sw)     rd_word = sw_s2;
        else if (hit_btn)    rd_word = {28'b0, btn_s2};
    end

    always_comb begin
        rd_byte = '0;
        case (bus.addr[1:0])
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = '0;
        endcase
        rd_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];

        ld_nxt = '0;
        if (bus.insn_vld && bus.is_load && !ld_mis) begin
            case (bus.load_sel)
                3'b000: ld_nxt = {{24{rd_byte[7]}}, rd_byte};
                3'b001: ld_nxt = {{16{rd_half[15]}}, rd_half};
                3'b010: ld_nxt = rd_word;
                3'b100: ld_nxt = {24'b0, rd_byte};
                3'b101: ld_nxt = {16'b0, rd_half};
                default: ld_nxt = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SNONE = 2'b11;
    localparam int unsigned R_NONE = 0, R_LEDR = 1, R_LEDG = 2, R_HLO = 3, R_HHI = 4, R_LCD = 5;

    typedef struct {
        logic        vld;
        logic        wren;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  lsel;
        logic [1:0]  ssel;
        logic [31:0] exp_ld;
        logic        exp_mis;
        int unsigned reg_sel;
        logic [31:0] exp_reg;
    } vec_t;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        string       nm;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_io_sw;
    logic [3:0]  i_io_btn;
    logic [31:0] o_io_ledr, o_io_ledg, o_io_hex_lo, o_io_hex_hi, o_io_lcd;

    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t        tbl[$];
    exp_t        sb[$];

    lsu_mem_stage_if bus();

    lsu_mem_stage #(.DMEM_DEPTH(2048), .DMEM_BASE(32'h0000_2000)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .bus         (bus),
        .i_io_sw     (i_io_sw),
        .i_io_btn    (i_io_btn),
        .o_io_ledr   (o_io_ledr),
        .o_io_ledg   (o_io_ledg),
        .o_io_hex_lo (o_io_hex_lo),
        .o_io_hex_hi (o_io_hex_hi),
        .o_io_lcd    (o_io_lcd)
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(logic vld, logic wren, logic ld, logic [31:0] a, logic [31:0] d,
                                logic [2:0] ls, logic [1:0] ss, logic [31:0] el, logic em,
                                int unsigned rs, logic [31:0] er);
        vec_t v;
        v.vld = vld; v.wren = wren; v.ld = ld; v.addr = a; v.data = d;
        v.lsel = ls; v.ssel = ss; v.exp_ld = el; v.exp_mis = em;
        v.reg_sel = rs; v.exp_reg = er;
        return v;
    endfunction

    function automatic vec_t vld_ld(logic [31:0] a, logic [2:0] ls, logic [31:0] el, logic em);
        return mk(1'b1, 1'b0, 1'b1, a, 32'h0, ls, SNONE, el, em, R_NONE, 32'h0);
    endfunction

    function automatic vec_t vld_st(logic [31:0] a, logic [31:0] d, logic [1:0] ss, logic em,
                                    int unsigned rs, logic [31:0] er);
        return mk(1'b1, 1'b1, 1'b0, a, d, 3'b111, ss, 32'h0, em, rs, er);
    endfunction

    function automatic logic [31:0] io_reg(int unsigned s);
        case (s)
            R_LEDR: return o_io_ledr;
            R_LEDG: return o_io_ledg;
            R_HLO:  return o_io_hex_lo;
            R_HHI:  return o_io_hex_hi;
            R_LCD:  return o_io_lcd;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one access, push its expected result, then pop and compare
    // once the registered output has been produced.
    task automatic issue(input vec_t v, input string nm);
        exp_t e;
        bus.insn_vld  = v.vld;
        bus.mem_wren  = v.wren;
        bus.is_load   = v.ld;
        bus.addr      = v.addr;
        bus.st_data   = v.data;
        bus.load_sel  = v.lsel;
        bus.store_sel = v.ssel;
        sb.push_back('{v.exp_ld, v.exp_mis, nm});
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        check({e.nm, "_ld"}, bus.ld_data, e.ld);
        check({e.nm, "_mis"}, {31'b0, bus.misalign}, {31'b0, e.mis});
        if (v.reg_sel != R_NONE)
            check({e.nm, "_io"}, io_reg(v.reg_sel), v.exp_reg);
    endtask

    task automatic nop(input string nm);
        issue(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, LW, SNONE, 32'h0, 1'b0, R_NONE, 32'h0), nm);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_io_sw = '0;
        i_io_btn = '0;
        bus.insn_vld = 1'b0; bus.mem_wren = 1'b0; bus.is_load = 1'b0;
        bus.addr = '0; bus.st_data = '0; bus.load_sel = LW; bus.store_sel = SNONE;

        // Reset: a store presented while in reset must not land.
        repeat (2) @(posedge i_clk);
        #1;
        issue(vld_st(32'h7010, 32'hFFFF_FFFF, SW, 1'b0, R_LEDG, 32'h0), "rst_store");
        check("rst_ledr", o_io_ledr, 32'h0);
        check("rst_hexlo", o_io_hex_lo, 32'h0);
        check("rst_hexhi", o_io_hex_hi, 32'h0);
        check("rst_lcd", o_io_lcd, 32'h0);
        i_rst_n = 1'b1;
        nop("post_rst");

        tbl.push_back(vld_ld(32'h7000, LW, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h7010, 32'hFFFF_FFFF, 3'b111, SW, 32'h0, 1'b0, R_LEDG, 32'h0));
        tbl.push_back(vld_st(32'h2000, 32'hDEAD_BEEF, SW, 1'b0, R_NONE, 32'h0));
        tbl.push_back(vld_ld(32'h2000, LW, 32'hDEAD_BEEF, 1'b0));
        tbl.push_back(vld_st(32'h2004, 32'h8000_00F0, SW, 1'b0, R_NONE, 32'h0));
        tbl.push_back(vld_ld(32'h2004, LB, 32'hFFFF_FFF0, 1'b0));
        tbl.push_back(vld_ld(32'h2004, LBU, 32'h0000_00F0, 1'b0));
        tbl.push_back(vld_ld(32'h2006, LH, 32'hFFFF_8000, 1'b0));
        tbl.push_back(vld_ld(32'h2006, LHU, 32'h0000_8000, 1'b0));
        tbl.push_back(vld_ld(32'h2007, LB, 32'hFFFF_FF80, 1'b0));
        tbl.push_back(vld_st(32'h7000, 32'h1122_3344, SW, 1'b0, R_LEDR, 32'h1122_3344));
        tbl.push_back(vld_st(32'h7002, 32'h0000_00AA, SB, 1'b0, R_LEDR, 32'h11AA_3344));
        tbl.push_back(vld_st(32'h2002, 32'h5555_5555, SW, 1'b1, R_NONE, 32'h0));
        tbl.push_back(vld_ld(32'h2000, LW, 32'hDEAD_BEEF, 1'b0));
        tbl.push_back(vld_ld(32'h2001, LH, 32'h0, 1'b1));
        tbl.push_back(vld_ld(32'h2006, LW, 32'h0, 1'b1));
        tbl.push_back(vld_st(32'h7012, 32'h0000_BEEF, SH, 1'b0, R_LEDG, 32'hBEEF_0000));
        tbl.push_back(vld_ld(32'h7010, LW, 32'hBEEF_0000, 1'b0));
        tbl.push_back(vld_st(32'h7031, 32'h0000_0012, SB, 1'b0, R_LCD, 32'h0000_1200));
        tbl.push_back(vld_ld(32'h7031, LBU, 32'h0000_0012, 1'b0));
        tbl.push_back(vld_ld(32'h2000, 3'b011, 32'h0, 1'b0));
        tbl.push_back(vld_st(32'h7024, 32'hFFFF_FFFF, SNONE, 1'b0, R_HHI, 32'h0));
        tbl.push_back(vld_st(32'h7020, 32'hCAFE_F00D, SW, 1'b0, R_HLO, 32'hCAFE_F00D));
        tbl.push_back(vld_ld(32'h7022, LHU, 32'h0000_CAFE, 1'b0));
        tbl.push_back(vld_st(32'h9000, 32'h1234_5678, SW, 1'b0, R_NONE, 32'h0));
        tbl.push_back(vld_ld(32'h9000, LW, 32'h0, 1'b0));
        tbl.push_back(vld_st(32'h3FFC, 32'h0BAD_F00D, SW, 1'b0, R_NONE, 32'h0));
        tbl.push_back(vld_ld(32'h3FFC, LW, 32'h0BAD_F00D, 1'b0));
        tbl.push_back(vld_ld(32'h4000, LW, 32'h0, 1'b0));
        tbl.push_back(vld_ld(32'h1FFC, LW, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h2000, 32'h0, LW, SNONE, 32'h0, 1'b0, R_NONE, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h2000, 32'h0, LW, SNONE, 32'h0, 1'b0, R_NONE, 32'h0));
        tbl.push_back(vld_st(32'h2002, 32'h0000_ABCD, SH, 1'b0, R_NONE, 32'h0));
        tbl.push_back(vld_ld(32'h2000, LW, 32'hABCD_BEEF, 1'b0));
        tbl.push_back(vld_st(32'h7001, 32'h0000_FFFF, SH, 1'b1, R_LEDR, 32'h11AA_3344));

        for (int i = 0; i < tbl.size(); i++)
            issue(tbl[i], $sformatf("v%0d", i));

        // Switch synchroniser: two edges before loads see the new value.
        i_io_sw = 32'h0000_5A5A;
        issue(vld_ld(32'h7800, LW, 32'h0, 1'b0), "sw_e0");
        issue(vld_ld(32'h7800, LW, 32'h0, 1'b0), "sw_e1");
        issue(vld_ld(32'h7800, LW, 32'h0000_5A5A, 1'b0), "sw_e2");
        issue(vld_st(32'h7800, 32'h0000_0000, SW, 1'b0, R_NONE, 32'h0), "sw_store");
        issue(vld_ld(32'h7800, LW, 32'h0000_5A5A, 1'b0), "sw_after_st");
        issue(vld_ld(32'h7801, LBU, 32'h0000_005A, 1'b0), "sw_byte1");

        i_io_btn = 4'hB;
        nop("btn_n0");
        nop("btn_n1");
        issue(vld_ld(32'h7810, LW, 32'h0000_000B, 1'b0), "btn_rd");

        // Mid-run reset clears registers but leaves DMEM intact.
        i_rst_n = 1'b0;
        nop("rst2");
        check("rst2_ledr", o_io_ledr, 32'h0);
        check("rst2_lcd", o_io_lcd, 32'h0);
        i_rst_n = 1'b1;
        issue(vld_ld(32'h2000, LW, 32'hABCD_BEEF, 1'b0), "dmem_kept");
        issue(vld_ld(32'h7800, LW, 32'h0, 1'b0), "sync_cleared");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
